// File: rtl/add32_accum_seq.sv
// add32_accum_seq: sequential accumulation controller around an external
// 32-bit adder. It feeds the adder with the accumulator (operand A) and the
// incoming word (operand B), then captures sum and carry-out on every accepted
// beat. When the last word of a packet is accepted, it presents the total, the
// beat count and the carry count until the downstream side takes them.
// Optional build macro: ADD32_SAT_EN selects saturating accumulation instead
// of modulo 2^32 wrap-around.
module add32_accum_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_carries
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      acc;
    logic [31:0]      acc_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] carries;
    logic             in_hs;
    logic             out_hs;

    assign in_ready    = (state != HOLD);
    assign out_valid   = (state == HOLD);
    assign in_hs       = in_valid && in_ready;
    assign out_hs      = out_valid && out_ready;

    assign add_a       = acc;
    assign add_b       = in_data;

    assign out_sum     = acc;
    assign out_count   = count;
    assign out_carries = carries;

    // Value the accumulator takes on an input handshake.
    always_comb begin
        acc_nxt = add_sum;
`ifdef ADD32_SAT_EN
        if (add_cout || (acc == 32'hFFFF_FFFF)) begin
            acc_nxt = 32'hFFFF_FFFF;
        end
`endif
    end

    // State register; reset drops any partial packet without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept beats until last, then hold until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_nxt = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_hs && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: accumulate and count on input beats, clear when result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 32'd0;
            count   <= '0;
            carries <= '0;
        end else if (out_hs) begin
            acc     <= 32'd0;
            count   <= '0;
            carries <= '0;
        end else if (in_hs) begin
            acc <= acc_nxt;
            if (count != CNT_MAX) begin
                count <= count + CNT_ONE;
            end
            if (add_cout && (carries != CNT_MAX)) begin
                carries <= carries + CNT_ONE;
            end
        end
    end

endmodule
